// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit types, port indices, field positions and the XY route function.
package noc_pkg;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_t;

  localparam int P_N = 4;
  localparam int P_S = 3;
  localparam int P_E = 2;
  localparam int P_W = 1;
  localparam int P_L = 0;

  // Type occupies the top TYPE_W bits; dx starts at DX_LSB, dy follows directly above dx.
  localparam int TYPE_W    = 2;
  localparam int DX_LSB    = 0;
  localparam int COORD_MAX = 8;

  function automatic logic [4:0] port_bit(input int p);
    return 5'(1) << p;
  endfunction

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [4:0] xy_route(input logic [COORD_MAX-1:0] dx,
                                          input logic [COORD_MAX-1:0] dy,
                                          input logic [COORD_MAX-1:0] x,
                                          input logic [COORD_MAX-1:0] y);
    if (dx > x)      return port_bit(P_E);
    else if (dx < x) return port_bit(P_W);
    else if (dy > y) return port_bit(P_N);
    else if (dy < y) return port_bit(P_S);
    else             return port_bit(P_L);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Generic circular FIFO: power-of-two depth, registered pointers and occupancy count.
module flit_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/router_input_queue.sv
// Router input buffer: FIFO plus per-packet XY route latch and protocol checker.
// Optional QUEUE_BYPASS_EN lets a flit cut through an empty queue in the same cycle.
module router_input_queue
  import noc_pkg::*;
#(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [FLIT_W-1:0]      in_flit,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [FLIT_W-1:0]      out_flit,
  output logic [4:0]             out_port,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   proto_err
);

  typedef enum logic {S_IDLE, S_PKT} state_t;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fire, is_head;
  logic [FLIT_W-1:0] fifo_rdata;
  flit_type_t        head_type;
  logic [4:0]        route_c;
  state_t            state_q;
  logic [4:0]        route_q;
  logic              proto_err_q;

  flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_flit),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;

`ifdef QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && in_valid;
  assign out_valid = !fifo_empty || in_valid;
  assign out_flit  = fifo_empty ? in_flit : fifo_rdata;
  assign fifo_push = in_valid && !fifo_full && !(bypass && out_ready);
`else
  assign out_valid = !fifo_empty;
  assign out_flit  = fifo_rdata;
  assign fifo_push = in_valid && !fifo_full;
`endif

  assign fire      = out_valid && out_ready;
  assign fifo_pop  = fire && !fifo_empty;
  assign head_type = flit_type_t'(out_flit[FLIT_W-1 -: TYPE_W]);
  assign is_head   = (head_type == HEAD) || (head_type == SINGLE);
  assign route_c   = xy_route(COORD_MAX'(out_flit[DX_LSB +: COORD_W]),
                              COORD_MAX'(out_flit[DX_LSB + COORD_W +: COORD_W]),
                              COORD_MAX'(X_COORD), COORD_MAX'(Y_COORD));

  // A stray BODY/TAIL with no open packet is delivered locally.
  always_comb begin
    out_port = '0;
    if (out_valid) begin
      if (is_head)               out_port = route_c;
      else if (state_q == S_PKT) out_port = route_q;
      else                       out_port = port_bit(P_L);
    end
  end

  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      route_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (out_valid && (is_head == (state_q == S_PKT))) proto_err_q <= 1'b1;
      if (fire) begin
        unique case (head_type)
          HEAD:   begin state_q <= S_PKT;  route_q <= route_c; end
          SINGLE: begin state_q <= S_IDLE; route_q <= route_c; end
          TAIL:   state_q <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule
